// File: rtl/dmem_responder.sv
// dmem_responder: zero-latency data memory with completion detect, watchdog and optional store trace.
// Optional store-trace FIFO is built only when DMEM_TRACE_EN is defined.
module dmem_responder #(
    parameter int          MEM_SIZE_WORDS = 1024,
    parameter logic [31:0] DONE_ADDR      = 32'h400,
    parameter int          MAX_CYCLES     = 15000,
    parameter int          TRACE_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_wdata,
    input  logic [3:0]  d_mem_wen,
    output logic [31:0] d_mem_rdata,
    output logic        done,
    output logic [31:0] done_value,
    output logic        timeout,
    output logic [31:0] cycle_count,
    output logic [15:0] wr_count,
    output logic        err_oob,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [3:0]  trace_wen,
    output logic        trace_ovf
);
    localparam int AW = $clog2(MEM_SIZE_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

    state_t        state;
    logic [31:0]   ram [MEM_SIZE_WORDS];
    logic [AW-1:0] idx;
    logic          in_range, any_wen, wr_ok, flag_hit, at_limit;

    assign idx         = d_mem_addr[AW+1:2];
    assign in_range    = d_mem_addr < 32'(4 * MEM_SIZE_WORDS);
    assign any_wen     = |d_mem_wen;
    assign wr_ok       = rst_n && in_range && any_wen;
    assign flag_hit    = any_wen && (d_mem_addr[31:2] == DONE_ADDR[31:2]) && (|d_mem_wdata);
    assign at_limit    = cycle_count == 32'(MAX_CYCLES - 1);
    assign d_mem_rdata = !rst_n ? '0 : in_range ? ram[idx] : 32'hDEADBEEF;

    // RAM: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_ok)
            for (int k = 0; k < 4; k++)
                if (d_mem_wen[k]) ram[idx][8*k +: 8] <= d_mem_wdata[8*k +: 8];
    end

    // run-state FSM: cycle counter, completion flag and watchdog; completion wins over the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            done        <= 1'b0;
            done_value  <= '0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (flag_hit) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        done_value  <= d_mem_wdata;
                        cycle_count <= cycle_count + 32'd1;
                    end else if (at_limit) begin
                        state   <= TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // store accounting: saturating accepted-store count and sticky out-of-range flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count <= '0;
            err_oob  <= 1'b0;
        end else begin
            if (wr_ok && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (any_wen && !in_range) err_oob <= 1'b1;
        end
    end

`ifdef DMEM_TRACE_EN
    localparam int TW = $clog2(TRACE_DEPTH);

    logic [67:0]   tq [TRACE_DEPTH];
    logic [TW-1:0] wp, rp;
    logic [TW:0]   cnt;
    logic          pop, full, acc;

    assign pop         = trace_valid && trace_ready;
    assign full        = cnt == (TW+1)'(TRACE_DEPTH);
    assign acc         = wr_ok && (!full || pop);
    assign trace_valid = cnt != '0;
    assign {trace_addr, trace_data, trace_wen} = trace_valid ? tq[rp] : '0;

    // trace storage: written only when a push is accepted
    always_ff @(posedge clk) begin
        if (acc) tq[wp] <= {d_mem_addr, d_mem_wdata, d_mem_wen};
    end

    // trace pointers, occupancy and sticky drop flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (acc) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (TW+1)'(acc) - (TW+1)'(pop);
            if (wr_ok && !acc) trace_ovf <= 1'b1;
        end
    end
`else
    logic unused_trace;

    assign unused_trace = &{1'b0, trace_ready, TRACE_DEPTH > 0};
    assign trace_valid  = 1'b0;
    assign trace_addr   = '0;
    assign trace_data   = '0;
    assign trace_wen    = '0;
    assign trace_ovf    = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with a queued scoreboard checked at the falling edge.
module tb_dmem_responder;
    localparam int MAXC = 40;
`ifdef DMEM_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
    logic [3:0]  d_mem_wen;
    logic        done, timeout, err_oob, trace_valid, trace_ready, trace_ovf;
    logic [31:0] done_value, cycle_count, trace_addr, trace_data;
    logic [15:0] wr_count;
    logic [3:0]  trace_wen;

    typedef struct {
        string       n;
        int          sel;
        logic [31:0] e;
    } chk_t;

    chk_t        cq[$];
    logic [67:0] tq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pops    = 0;

    dmem_responder #(.MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata), .d_mem_wen(d_mem_wen),
        .d_mem_rdata(d_mem_rdata), .done(done), .done_value(done_value),
        .timeout(timeout), .cycle_count(cycle_count), .wr_count(wr_count),
        .err_oob(err_oob), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_addr(trace_addr), .trace_data(trace_data), .trace_wen(trace_wen),
        .trace_ovf(trace_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(int s);
        case (s)
            0:       return d_mem_rdata;
            1:       return {31'd0, done};
            2:       return done_value;
            3:       return {31'd0, timeout};
            4:       return cycle_count;
            5:       return {16'd0, wr_count};
            6:       return {31'd0, err_oob};
            7:       return {31'd0, trace_valid};
            8:       return {31'd0, trace_ovf};
            default: return trace_addr;
        endcase
    endfunction

    // monitor: drains queued expectations and checks every trace handshake
    always @(negedge clk) begin
        chk_t        c;
        logic [67:0] t;
        while (cq.size() > 0) begin
            c = cq.pop_front();
            n_tests++;
            if (obs(c.sel) !== c.e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.n, obs(c.sel), c.e);
            end
        end
        if (trace_valid && trace_ready) begin
            pops++;
            n_tests++;
            if (tq.size() == 0) begin
                n_fail++;
                $display("FAIL trace_pop: got %h_%h_%h expected none", trace_addr, trace_data, trace_wen);
            end else begin
                t = tq.pop_front();
                if ({trace_addr, trace_data, trace_wen} !== t) begin
                    n_fail++;
                    $display("FAIL trace_pop: got %h_%h_%h expected %h", trace_addr, trace_data, trace_wen, t);
                end
            end
        end
    end

    task automatic chk(input string n, input int s, input logic [31:0] e);
        chk_t c;
        c.n = n;
        c.sel = s;
        c.e = e;
        cq.push_back(c);
    endtask

    task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        d_mem_addr = a;
        d_mem_wdata = d;
        d_mem_wen = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        drv(32'h200, 0, 4'h0);
        chk("rdata_in_reset", 0, 32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        trace_ready = 1'b0;
        drv(32'h300, 32'hFFFFFFFF, 4'hF);
        tick();
        tick();
        drv(32'h200, 0, 4'h0);
        chk("rst_rdata", 0, 32'h0);
        chk("rst_done", 1, 32'h0);
        chk("rst_done_value", 2, 32'h0);
        chk("rst_timeout", 3, 32'h0);
        chk("rst_cycle", 4, 32'h0);
        chk("rst_wr_count", 5, 32'h0);
        chk("rst_err_oob", 6, 32'h0);
        chk("rst_trace_valid", 7, 32'h0);
        chk("rst_trace_ovf", 8, 32'h0);
        tick();
        rst_n = 1'b1;
        chk("idle_cycle", 4, 32'h0);
        chk("idle_wr_count", 5, 32'h0);
        tick();
        // RUN cycle 0: byte lanes
        drv(32'h200, 32'h11223344, 4'hF);
        chk("run0_cycle", 4, 32'h0);
        tick();
        drv(32'h200, 32'h0000AA00, 4'b0010);
        chk("no_write_through", 0, 32'h11223344);
        chk("wr_count_1", 5, 32'd1);
        tick();
        drv(32'h200, 0, 4'h0);
        chk("byte_lane", 0, 32'h1122AA44);
        chk("wr_count_2", 5, 32'd2);
        tick();
        drv(32'h203, 0, 4'h0);
        chk("addr_low_bits", 0, 32'h1122AA44);
        tick();
        // range checks
        drv(32'h1000, 0, 4'h0);
        chk("oob_read", 0, 32'hDEADBEEF);
        chk("oob_clear", 6, 32'h0);
        tick();
        drv(32'h1000, 32'h12345678, 4'hF);
        tick();
        drv(32'hFFC, 32'hCAFEF00D, 4'hF);
        chk("oob_set", 6, 32'h1);
        chk("oob_wr_count", 5, 32'd2);
        tick();
        drv(32'hFFC, 0, 4'h0);
        chk("top_word", 0, 32'hCAFEF00D);
        chk("wr_count_3", 5, 32'd3);
        tick();
        // completion
        drv(32'h400, 32'h0, 4'hF);
        tick();
        drv(32'h400, 0, 4'h0);
        chk("zero_flag_done", 1, 32'h0);
        chk("zero_flag_ram", 0, 32'h0);
        chk("wr_count_4", 5, 32'd4);
        tick();
        drv(32'h200, 0, 4'h0);
        repeat (27) tick();
        drv(32'h400, 32'h1, 4'hF);
        chk("cycle_37", 4, 32'd37);
        chk("pre_done", 1, 32'h0);
        tick();
        drv(32'h400, 32'h77, 4'hF);
        chk("done", 1, 32'h1);
        chk("done_value", 2, 32'h1);
        chk("done_cycle", 4, 32'd38);
        chk("done_no_timeout", 3, 32'h0);
        tick();
        drv(32'h400, 0, 4'h0);
        chk("post_done_value", 2, 32'h1);
        chk("post_done_ram", 0, 32'h77);
        chk("wr_count_6", 5, 32'd6);
        tick();
        repeat (5) tick();
        chk("frozen_cycle", 4, 32'd38);
        chk("frozen_no_timeout", 3, 32'h0);
        tick();
        // reset mid-run
        pulse_reset();
        drv(32'h200, 0, 4'h0);
        chk("rr_done", 1, 32'h0);
        chk("rr_done_value", 2, 32'h0);
        chk("rr_cycle", 4, 32'h0);
        chk("rr_wr_count", 5, 32'h0);
        chk("rr_err_oob", 6, 32'h0);
        chk("ram_retained", 0, 32'h1122AA44);
        tick();
        chk("rr_run0", 4, 32'h0);
        tick();
        // watchdog
        repeat (38) tick();
        chk("wd_cycle_39", 4, 32'd39);
        chk("wd_pre", 3, 32'h0);
        tick();
        drv(32'h400, 32'h5, 4'hF);
        chk("wd_timeout", 3, 32'h1);
        chk("wd_cycle_hold", 4, 32'd39);
        chk("wd_no_done", 1, 32'h0);
        tick();
        drv(32'h400, 0, 4'h0);
        chk("wd_flag_ignored", 1, 32'h0);
        chk("wd_ram_live", 0, 32'h5);
        chk("wd_wr_count", 5, 32'd1);
        chk("wd_cycle_frozen", 4, 32'd39);
        tick();
        // completion and limit in the same cycle
        pulse_reset();
        tick();
        tick();
        repeat (38) tick();
        drv(32'h400, 32'h9, 4'hF);
        chk("tie_cycle_39", 4, 32'd39);
        tick();
        drv(32'h200, 0, 4'h0);
        chk("tie_done", 1, 32'h1);
        chk("tie_timeout", 3, 32'h0);
        chk("tie_done_value", 2, 32'h9);
        chk("tie_cycle", 4, 32'd40);
        tick();
        // trace FIFO
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            drv(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'(i + 1));
            if (TR && i < 8) tq.push_back({32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'(i + 1)});
            if (i == 0) chk("trace_no_bypass", 7, 32'h0);
            if (i == 1) chk("trace_valid_rise", 7, {31'd0, TR});
            tick();
        end
        drv(32'h200, 0, 4'h0);
        chk("trace_ovf", 8, {31'd0, TR});
        chk("trace_full_valid", 7, {31'd0, TR});
        chk("trace_head", 9, TR ? 32'h100 : 32'h0);
        tick();
        trace_ready = 1'b1;
        repeat (10) tick();
        chk("trace_drained", 7, 32'h0);
        tick();
        n_tests++;
        if (pops != (TR ? 8 : 0) || tq.size() != 0) begin
            n_fail++;
            $display("FAIL trace_pops: got %0d pops %0d left expected %0d pops 0 left", pops, tq.size(), TR ? 8 : 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
